// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the instruction-fetch and data (load/store) ports onto
// a single word-addressed memory. Each granted transaction runs through
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP. All outputs are registered.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking;
// otherwise the data port wins every tie.
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              busy,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(MEM_WORDS);
    localparam logic [3:0]        CNT_INIT   = 4'(WAIT_CYCLES);
    localparam bit                ZERO_WAIT  = (WAIT_CYCLES == 0);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_owner_d;   // 1 = data port owns the transaction
    logic              r_we;
    logic              r_bad;
    logic              r_if_ready;
    logic              r_d_ready;
    logic              r_err;
    logic              r_busy;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_any;
    logic              w_pick_d;
    logic              w_we;
    logic              w_bad;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;

`ifdef MEM_ARB_RR_EN
    logic              r_last_d;    // most recent contested winner, 0 = fetch

    // Round-robin: on a tie the port not granted last wins.
    assign w_pick_d = d_req & (~if_req | ~r_last_d);

    // Last-grant bit moves only when both ports contended for the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_d <= 1'b0;
        else if (r_state == S_IDLE && if_req && d_req)
            r_last_d <= w_pick_d;
    end
`else
    // Fixed priority: data wins every tie.
    assign w_pick_d = d_req;
`endif

    assign w_any   = if_req | d_req;
    assign w_addr  = w_pick_d ? d_addr : if_addr;
    assign w_we    = w_pick_d & d_we;
    assign w_bad   = (w_addr >= ADDR_LIMIT);
    // An out-of-range read returns zero rather than whatever the memory drives.
    assign w_rdata = r_bad ? '0 : mem_read_data;

    // Transaction sequencer: grant, drive the memory, capture data, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_bad       <= 1'b0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner_d   <= w_pick_d;
                        r_we        <= w_we;
                        r_bad       <= w_bad;
                        r_mem_addr  <= w_addr;
                        if (w_pick_d)
                            r_mem_wdata <= d_wdata;
                        r_cnt       <= CNT_INIT;
                        r_mem_read  <= ~w_we & ~w_bad;
                        // With no wait cycles the first ACCESS cycle is also the last.
                        r_mem_write <= w_we & ~w_bad & ZERO_WAIT;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                        // Raise the write strobe for the final ACCESS cycle only.
                        if (r_cnt == 4'd1)
                            r_mem_write <= r_we & ~r_bad;
                    end else begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_err       <= r_bad;
                        if (r_owner_d)
                            r_d_ready  <= 1'b1;
                        else
                            r_if_ready <= 1'b1;
                        if (!r_we) begin
                            if (r_owner_d)
                                r_d_rdata  <= w_rdata;
                            else
                                r_if_rdata <= w_rdata;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ready       = r_if_ready;
    assign if_rdata       = r_if_rdata;
    assign d_ready        = r_d_ready;
    assign d_rdata        = r_d_rdata;
    assign err            = r_err;
    assign busy           = r_busy;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;

endmodule
